// File: rtl/dff_bank_arbiter_if.sv
// Bus interface between client FSMs, the bank write arbiter and the bank.
// The master modport is the client/bank side and the slave modport is the arbiter.
//   req      client -> arbiter   one bit per requester, held until done
//   wdata    client -> arbiter   packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt      arbiter -> client   one-hot grant for the whole transaction
//   done     arbiter -> client   one-cycle completion pulse
//   bank_d   arbiter -> bank     data to the bank D inputs
//   bank_en  arbiter -> bank     bank enable
//   bank_clr arbiter -> bank     bank clear (active-high)
//   bank_q   bank -> arbiter     bank Q outputs (read only with READBACK_VERIFY_EN)
//   busy     arbiter -> client   arbiter is mid-transaction
//   err      arbiter -> client   sticky readback failure (only with READBACK_VERIFY_EN)
interface dff_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      bank_d;
  logic                  bank_en;
  logic                  bank_clr;
  logic [WIDTH-1:0]      bank_q;
  logic                  busy;
`ifdef READBACK_VERIFY_EN
  logic                  err;
`endif

  modport master (
    output req, wdata, bank_q,
`ifdef READBACK_VERIFY_EN
    input  err,
`endif
    input  gnt, done, bank_d, bank_en, bank_clr, busy
  );

  modport slave (
    input  req, wdata,
`ifdef READBACK_VERIFY_EN
    input  bank_q,
    output err,
`endif
    output gnt, done, bank_d, bank_en, bank_clr, busy
  );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter/sequencer for a shared register bank made of slow
// gate-level enable flops. One requester is granted, its data is latched onto
// bank_d, bank_en is held for HOLD_CYCLES cycles, one settle cycle follows and
// then done pulses to the winner.
// Ports:
//   clk  rising-edge system clock
//   rst  synchronous active-low reset
//   bus  dff_bank_arbiter_if.slave (req/wdata in, gnt/done/bank_*/busy out)
// Optional feature macro READBACK_VERIFY_EN: adds a CHECK state that compares
// bank_q against bank_d, retries the write once on mismatch and raises the
// sticky err output if the retry also mismatches.
module dff_bank_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  dff_bank_arbiter_if.slave   bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    SETTLE = 3'd2,
`ifdef READBACK_VERIFY_EN
    CHECK  = 3'd3,
`endif
    DONE   = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [NREQ-1:0]   gnt_r;
  logic [WIDTH-1:0]  bank_d_r;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     rr;
  logic [IW-1:0]     gidx;
  logic              bank_clr_r;
  logic              pick_vld;
  logic [IW-1:0]     pick_idx;
  logic [NREQ-1:0]   pick_oh;
  logic [WIDTH-1:0]  pick_data;
  logic [IW-1:0]     rr_next;
  logic              grant_ld;
  logic              cnt_inc;
  logic              gnt_clr;
`ifdef READBACK_VERIFY_EN
  logic              retry;
  logic              err_r;
  logic              retry_set;
  logic              err_set;
  logic              cnt_clr;
`endif

  // Round-robin pick: first set req at or after rr, wrapping past NREQ-1.
  int          sum;
  logic [IW-1:0] idx;
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    sum      = 0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = int'(rr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = IW'(sum);
      if (!pick_vld && bus.req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
  end

  // Decode the winner into a one-hot grant and select its write data.
  always_comb begin
    pick_oh   = '0;
    pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        pick_oh[i] = 1'b1;
        pick_data  = bus.wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // The requester just served drops to lowest priority.
  assign rr_next = (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    grant_ld  = 1'b0;
    cnt_inc   = 1'b0;
    gnt_clr   = 1'b0;
`ifdef READBACK_VERIFY_EN
    retry_set = 1'b0;
    err_set   = 1'b0;
    cnt_clr   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_n  = WRITE;
          grant_ld = 1'b1;
        end
      end
      WRITE: begin
        if (cnt == CNT_LAST) state_n = SETTLE;
        else                 cnt_inc = 1'b1;
      end
      SETTLE: begin
`ifdef READBACK_VERIFY_EN
        state_n = CHECK;
`else
        state_n = DONE;
`endif
      end
`ifdef READBACK_VERIFY_EN
      CHECK: begin
        if (bus.bank_q == bank_d_r) begin
          state_n = DONE;
        end else if (!retry) begin
          // First mismatch: rewrite the same latched data once.
          state_n   = WRITE;
          retry_set = 1'b1;
          cnt_clr   = 1'b1;
        end else begin
          state_n = DONE;
          err_set = 1'b1;
        end
      end
`endif
      DONE: begin
        state_n = IDLE;
        gnt_clr = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Grant, latched data, hold counter, round-robin pointer and bank clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_r      <= '0;
      bank_d_r   <= '0;
      cnt        <= '0;
      rr         <= '0;
      gidx       <= '0;
      bank_clr_r <= 1'b1;
`ifdef READBACK_VERIFY_EN
      retry      <= 1'b0;
      err_r      <= 1'b0;
`endif
    end else begin
      bank_clr_r <= 1'b0;
      if (grant_ld) begin
        gnt_r    <= pick_oh;
        bank_d_r <= pick_data;
        gidx     <= pick_idx;
        cnt      <= '0;
`ifdef READBACK_VERIFY_EN
        retry    <= 1'b0;
`endif
      end
      if (cnt_inc) cnt <= cnt + CW'(1);
      if (gnt_clr) begin
        gnt_r <= '0;
        rr    <= rr_next;
      end
`ifdef READBACK_VERIFY_EN
      if (cnt_clr)   cnt   <= '0;
      if (retry_set) retry <= 1'b1;
      if (err_set)   err_r <= 1'b1;
`endif
    end
  end

  assign bus.gnt      = gnt_r;
  assign bus.done     = (state == DONE) ? gnt_r : '0;
  assign bus.bank_d   = bank_d_r;
  assign bus.bank_en  = (state == WRITE);
  assign bus.bank_clr = bank_clr_r;
  assign bus.busy     = (state != IDLE);
`ifdef READBACK_VERIFY_EN
  assign bus.err      = err_r;
`endif

endmodule

// File: tb/tb_dff_bank_arbiter.sv
module tb_dff_bank_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  dff_bank_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

  dff_bank_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_oh;
    logic [7:0] exp_d;
    rst       = 1'b0;
    bus.req   = '0;
    bus.wdata = '0;
    bus.bank_q = '0;

    // 1: reset
    tick(); tick();
    chk("rst_gnt",      32'(bus.gnt),      32'h0);
    chk("rst_done",     32'(bus.done),     32'h0);
    chk("rst_bank_d",   32'(bus.bank_d),   32'h0);
    chk("rst_bank_en",  32'(bus.bank_en),  32'h0);
    chk("rst_busy",     32'(bus.busy),     32'h0);
    chk("rst_bank_clr", 32'(bus.bank_clr), 32'h1);
    rst = 1'b1;
    tick();
    chk("rel_bank_clr", 32'(bus.bank_clr), 32'h0);
    chk("idle_busy",    32'(bus.busy),     32'h0);

    // 2: single write from requester 2
    bus.wdata = 32'h00A5_0000;
    bus.req   = 4'b0100;
    tick();
    chk("t2_gnt",    32'(bus.gnt),     32'h4);
    chk("t2_bank_d", 32'(bus.bank_d),  32'hA5);
    chk("t2_en0",    32'(bus.bank_en), 32'h1);
    chk("t2_busy",   32'(bus.busy),    32'h1);
    chk("t2_done0",  32'(bus.done),    32'h0);
    tick();
    chk("t2_en1",    32'(bus.bank_en), 32'h1);
    tick();
    chk("t2_settle_en", 32'(bus.bank_en), 32'h0);
    chk("t2_done_early", 32'(bus.done),   32'h0);
    tick();
    chk("t2_done",   32'(bus.done),    32'h4);
    chk("t2_gnt_dn", 32'(bus.gnt),     32'h4);
    bus.req = '0;
    tick();
    chk("t2_done_off", 32'(bus.done), 32'h0);
    chk("t2_busy_off", 32'(bus.busy), 32'h0);
    chk("t2_gnt_off",  32'(bus.gnt),  32'h0);

    // 3: fairness from a fresh pointer with all requesters held
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.wdata = 32'h4433_2211;
    bus.req   = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_oh = 4'b0001 << (i % 4);
      exp_d  = 8'h11 * 8'((i % 4) + 1);
      chk("t3_gnt",    32'(bus.gnt),    32'(exp_oh));
      chk("t3_bank_d", 32'(bus.bank_d), 32'(exp_d));
      tick(); tick(); tick();
      chk("t3_done",   32'(bus.done),   32'(exp_oh));
      if (i == 4) bus.req = '0;
      tick();
    end
    chk("t3_idle", 32'(bus.busy), 32'h0);

    // 4: reset during WRITE aborts; requester 1 re-served afterwards
    bus.wdata = 32'h0000_5A00;
    bus.req   = 4'b0010;
    tick();
    chk("t4_gnt",  32'(bus.gnt),     32'h2);
    chk("t4_en",   32'(bus.bank_en), 32'h1);
    rst = 1'b0;
    tick();
    chk("t4_abort_gnt", 32'(bus.gnt),      32'h0);
    chk("t4_abort_en",  32'(bus.bank_en),  32'h0);
    chk("t4_abort_dn",  32'(bus.done),     32'h0);
    chk("t4_abort_clr", 32'(bus.bank_clr), 32'h1);
    rst = 1'b1;
    tick();
    chk("t4_regnt",  32'(bus.gnt),      32'h2);
    chk("t4_clr_lo", 32'(bus.bank_clr), 32'h0);
    chk("t4_data",   32'(bus.bank_d),   32'h5A);
    tick();
    chk("t4_dn_mid", 32'(bus.done), 32'h0);
    tick(); tick();
    chk("t4_done", 32'(bus.done), 32'h2);
    bus.req = '0;
    tick();

    // 5: req dropped in SETTLE and wdata changed in WRITE
    bus.wdata = 32'hC300_0000;
    bus.req   = 4'b1000;
    tick();
    chk("t5_gnt",  32'(bus.gnt),    32'h8);
    chk("t5_data", 32'(bus.bank_d), 32'hC3);
    bus.wdata = 32'hFF00_0000;
    tick();
    chk("t5_data_hold", 32'(bus.bank_d), 32'hC3);
    tick();
    bus.req = '0;
    tick();
    chk("t5_done",      32'(bus.done),   32'h8);
    chk("t5_data_done", 32'(bus.bank_d), 32'hC3);
    tick();
    chk("t5_idle", 32'(bus.busy), 32'h0);
    tick();
    chk("t5_idle_hold", 32'(bus.bank_d), 32'hC3);
    chk("t5_idle_gnt",  32'(bus.gnt),    32'h0);

`ifdef READBACK_VERIFY_EN
    // 6: readback mismatch retries once then sets err; match case passes clean
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.wdata  = 32'h0000_003C;
    bus.bank_q = 8'h00;
    bus.req    = 4'b0001;
    tick();
    tick(); tick(); tick();
    chk("t6_check_en", 32'(bus.bank_en), 32'h0);
    chk("t6_check_dn", 32'(bus.done),    32'h0);
    tick();
    chk("t6_retry_en", 32'(bus.bank_en), 32'h1);
    tick(); tick(); tick();
    chk("t6_err_pre", 32'(bus.err), 32'h0);
    tick();
    chk("t6_done", 32'(bus.done), 32'h1);
    chk("t6_err",  32'(bus.err),  32'h1);
    bus.req = '0;
    tick();
    chk("t6_err_sticky", 32'(bus.err), 32'h1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.bank_q = 8'h3C;
    bus.req    = 4'b0001;
    tick();
    tick(); tick(); tick(); tick();
    chk("t6_ok_done", 32'(bus.done), 32'h1);
    chk("t6_ok_err",  32'(bus.err),  32'h0);
    bus.req = '0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
